// File: rtl/clocker_ctrl.sv
// Sequences CPU clock-mode changes from two round-robin requesters: source
// select first, then divider, each followed by a settle interval on the fixed clock.
module clocker_ctrl #(
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [1:0] req0_mode,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_mode,
    output logic       req1_ready,
    output logic       clksel,
    output logic       divsel,
    output logic [1:0] cur_mode,
    output logic       busy,
    output logic       done,
    output logic       done_id
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_reg, state_next;
    logic             clksel_reg, clksel_next;
    logic             divsel_reg, divsel_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       target_reg, target_next;
    logic             id_reg, id_next;
    logic             prio_reg, prio_next;   // requester favoured when both are valid

    logic             grant;
    logic             xfer;
    logic [1:0]       grant_mode;

    always_comb begin
        grant = prio_reg;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state_reg == IDLE) && req0_valid && !grant;
    assign req1_ready = (state_reg == IDLE) && req1_valid && grant;
    assign xfer       = req0_ready || req1_ready;
    assign grant_mode = grant ? req1_mode : req0_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            clksel_reg <= 1'b0;
            divsel_reg <= 1'b0;
            cnt_reg    <= '0;
            target_reg <= 2'b00;
            id_reg     <= 1'b0;
            prio_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            clksel_reg <= clksel_next;
            divsel_reg <= divsel_next;
            cnt_reg    <= cnt_next;
            target_reg <= target_next;
            id_reg     <= id_next;
            prio_reg   <= prio_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        clksel_next = clksel_reg;
        divsel_next = divsel_reg;
        cnt_next    = cnt_reg;
        target_next = target_reg;
        id_next     = id_reg;
        prio_next   = prio_reg;

        case (state_reg)
            IDLE: begin
                if (xfer) begin
                    target_next = grant_mode;
                    id_next     = grant;
                    prio_next   = ~grant;
                    if (grant_mode == {clksel_reg, divsel_reg}) begin
                        state_next = DONE;
                    end else if (grant_mode[1] != clksel_reg) begin
                        clksel_next = grant_mode[1];
                        cnt_next    = CNT_LOAD;
                        state_next  = SEL_WAIT;
                    end else begin
                        divsel_next = grant_mode[0];
                        cnt_next    = CNT_LOAD;
                        state_next  = DIV_WAIT;
                    end
                end
            end
            SEL_WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else if (target_reg[0] != divsel_reg) begin
                    // Divider only moves once the new source has settled.
                    divsel_next = target_reg[0];
                    cnt_next    = CNT_LOAD;
                    state_next  = DIV_WAIT;
                end else begin
                    state_next = DONE;
                end
            end
            DIV_WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign clksel   = clksel_reg;
    assign divsel   = divsel_reg;
    assign cur_mode = {clksel_reg, divsel_reg};
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign done_id  = (state_reg == DONE) && id_reg;

endmodule

// File: tb/tb_clocker_ctrl.sv
// Bench for clocker_ctrl: table of requests with a done scoreboard, plus
// hand-written reset-mid-sequence, busy-ignore and no-change sequences.
module tb_clocker_ctrl;

    localparam int S = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0;
    logic [1:0] req0_mode = 2'b00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [1:0] req1_mode = 2'b00;
    logic       req1_ready;
    logic       clksel;
    logic       divsel;
    logic [1:0] cur_mode;
    logic       busy;
    logic       done;
    logic       done_id;

    always #5 clk = ~clk;

    clocker_ctrl #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_mode  (req0_mode),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_mode  (req1_mode),
        .req1_ready (req1_ready),
        .clksel     (clksel),
        .divsel     (divsel),
        .cur_mode   (cur_mode),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id)
    );

    typedef struct {
        int         id;
        logic [1:0] mode;
        int         lat;
        int         xcyc;
    } exp_t;

    typedef struct {
        logic       v0;
        logic [1:0] m0;
        logic       v1;
        logic [1:0] m1;
        int         id;
        logic [1:0] mode;
        int         lat;
    } vec_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   check_cnt = 0;
    int   ncyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and watches output ordering.
    logic prev_clksel = 1'b0;
    logic prev_divsel = 1'b0;
    logic prev_done   = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (rst_n) begin
            if (req0_ready || req1_ready) begin
                check("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
            end
            if (clksel !== prev_clksel || divsel !== prev_divsel) begin
                check("no_dual_toggle", {31'd0, (clksel !== prev_clksel) && (divsel !== prev_divsel)}, 32'd0);
                check("cur_mode_track", {30'd0, cur_mode}, {30'd0, clksel, divsel});
            end
            if (done) begin
                check("done_single_cycle", {31'd0, prev_done}, 32'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_id", {31'd0, done_id}, e.id);
                    check("done_mode", {30'd0, cur_mode}, {30'd0, e.mode});
                    check("done_latency", ncyc - e.xcyc, e.lat);
                    check("busy_in_done", {31'd0, busy}, 32'd1);
                end
            end
        end
        prev_clksel = clksel;
        prev_divsel = divsel;
        prev_done   = done;
    end

    task automatic start_req(input logic v0, input logic [1:0] m0, input logic v1, input logic [1:0] m1,
                             input int exp_id, input logic [1:0] exp_mode, input int exp_lat, input bit track);
        int budget;
        bit got;
        budget = 0;
        got    = 1'b0;
        @(negedge clk);
        #1;
        req0_valid = v0;
        req0_mode  = m0;
        req1_valid = v1;
        req1_mode  = m1;
        #1;
        forever begin
            if (req0_ready || req1_ready) begin
                got = 1'b1;
                check("grant_id", {31'd0, req1_ready}, exp_id);
                check("accept_latency", budget, 0);
                if (track) sb_q.push_back('{exp_id, exp_mode, exp_lat, ncyc});
            end
            @(posedge clk);
            if (got) break;
            budget++;
            if (budget > 40) begin
                check("ready_timeout", budget, 0);
                break;
            end
            @(negedge clk);
            #2;
        end
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while (sb_q.size() != 0 && budget < 60) begin
            @(negedge clk);
            #2;
            budget++;
        end
        check("done_seen", sb_q.size(), 0);
        sb_q.delete();
    endtask

    vec_t vt[10];

    initial begin
        vt[0] = '{1'b1, 2'b10, 1'b0, 2'b00, 0, 2'b10, S + 1};
        vt[1] = '{1'b1, 2'b00, 1'b0, 2'b00, 0, 2'b00, S + 1};
        vt[2] = '{1'b0, 2'b00, 1'b1, 2'b11, 1, 2'b11, 2 * S + 1};
        vt[3] = '{1'b1, 2'b01, 1'b1, 2'b10, 0, 2'b01, S + 1};
        vt[4] = '{1'b1, 2'b01, 1'b1, 2'b10, 1, 2'b10, 2 * S + 1};
        vt[5] = '{1'b1, 2'b00, 1'b1, 2'b11, 0, 2'b00, S + 1};
        vt[6] = '{1'b1, 2'b11, 1'b1, 2'b01, 1, 2'b01, S + 1};
        vt[7] = '{1'b1, 2'b01, 1'b0, 2'b00, 0, 2'b01, 1};
        vt[8] = '{1'b0, 2'b00, 1'b1, 2'b01, 1, 2'b01, 1};
        vt[9] = '{1'b1, 2'b00, 1'b0, 2'b00, 0, 2'b00, S + 1};

        repeat (2) @(negedge clk);
        #1;
        check("rst_clksel", {31'd0, clksel}, 32'd0);
        check("rst_divsel", {31'd0, divsel}, 32'd0);
        check("rst_cur_mode", {30'd0, cur_mode}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_done_id", {31'd0, done_id}, 32'd0);
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            start_req(vt[i].v0, vt[i].m0, vt[i].v1, vt[i].m1, vt[i].id, vt[i].mode, vt[i].lat, 1'b1);
            wait_done();
            $display("vec %0d: id=%0d mode=%b lat=%0d", i, vt[i].id, vt[i].mode, vt[i].lat);
        end

        // Reset in the middle of a source change drops the request silently.
        start_req(1'b1, 2'b10, 1'b0, 2'b00, 0, 2'b10, S + 1, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("mid_clksel_set", {31'd0, clksel}, 32'd1);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_clksel", {31'd0, clksel}, 32'd0);
        check("mid_rst_divsel", {31'd0, divsel}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        start_req(1'b1, 2'b01, 1'b1, 2'b10, 0, 2'b01, S + 1, 1'b1);
        wait_done();
        $display("seq reset-mid: post-reset grant to req0");

        // A req1 pulse while busy is ignored and never replayed.
        start_req(1'b1, 2'b11, 1'b0, 2'b00, 0, 2'b11, S + 1, 1'b1);
        @(negedge clk);
        #1;
        req1_valid = 1'b1;
        req1_mode  = 2'b00;
        #1;
        check("busy_pulse_ready1", {31'd0, req1_ready}, 32'd0);
        check("busy_pulse_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        #1;
        req1_valid = 1'b0;
        wait_done();
        repeat (12) @(negedge clk);
        #1;
        check("idle_after_pulse_busy", {31'd0, busy}, 32'd0);
        check("idle_after_pulse_mode", {30'd0, cur_mode}, 32'd3);
        $display("seq busy-ignore: req1 pulse dropped");

        // No-change request: busy for exactly the DONE cycle.
        start_req(1'b0, 2'b00, 1'b1, 2'b11, 1, 2'b11, 1, 1'b1);
        @(negedge clk);
        #1;
        check("nochg_busy_hi", {31'd0, busy}, 32'd1);
        check("nochg_done_hi", {31'd0, done}, 32'd1);
        @(negedge clk);
        #1;
        check("nochg_busy_lo", {31'd0, busy}, 32'd0);
        check("nochg_done_lo", {31'd0, done}, 32'd0);
        wait_done();
        $display("seq no-change: req1 mode=11");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/clocker_ctrl.md
Name: clocker_ctrl

Overview:
- Arbitrates and sequences clock-mode change requests for the CPU clock mux/divider.
- Two requesters, e.g. the Z80 port-write decoder and the boot sequencer, each ask for a target mode {clksel, divsel}.
- The block grants one request at a time, round-robin, and applies source selection before divider selection.
- It waits a settle interval after each change and signals completion. It runs on the fixed oscillator clock, never on the switched clock.

Parameters:
- SETTLE_CYCLES, 8: clk cycles held after each output change before the next step. Must be at least 1.
- CNT_W, 4: settle counter width. Must hold SETTLE_CYCLES-1.

Ports:
- clk  in  1  fixed oscillator clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a pending mode request.
- req0_mode  in  2  requester 0 target: [1]=clksel, [0]=divsel.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req1_valid  in  1  requester 1 pending request.
- req1_mode  in  2  requester 1 target mode.
- req1_ready  out  1  requester 1 accepted this cycle.
- clksel  out  1  registered clock source select to the mux.
- divsel  out  1  registered divide-by-2 select to the mux.
- cur_mode  out  2  {clksel, divsel} as currently driven.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a request completes.
- done_id  out  1  requester index of the completed request; valid when done=1.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - State IDLE.
  - clksel=0, divsel=0, busy=0, done=0, done_id=0.
  - Round-robin pointer favours req0.
  - Settle counter = 0.
  - Target and id registers cleared.
  - req*_ready=0.
- Reset mid-sequence: any in-flight request is dropped with no done pulse, and the outputs return to 00 immediately.
- Handshake:
  - reqN_ready is combinational: state==IDLE && reqN_valid && grant==N.
  - A transfer occurs on the clk edge where valid and ready are both 1.
  - Requesters hold valid and mode stable until ready.
  - Dropping valid before ready is legal; no transfer, no side effect.
  - At most one ready is high in any cycle.
- Arbitration (IDLE only):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not granted at the previous transfer. The first grant after reset is req0.
  - The pointer updates only on a transfer.
- State IDLE, on a transfer: latch target mode and id.
  - If target == cur_mode: go to DONE.
  - Else if target[1] != clksel: clksel <= target[1], counter <= SETTLE_CYCLES-1, go to SEL_WAIT.
  - Else: divsel <= target[0], counter <= SETTLE_CYCLES-1, go to DIV_WAIT.
- State SEL_WAIT:
  - While counter != 0: decrement.
  - At counter == 0, if target[0] != divsel: divsel <= target[0], reload counter, go to DIV_WAIT.
  - At counter == 0 otherwise: go to DONE.
- State DIV_WAIT: decrement the counter; at 0, go to DONE.
- State DONE: done=1 and done_id=latched id for exactly one cycle, then go to IDLE. No request is accepted in DONE.
- clksel and divsel never change in the same cycle. clksel always changes before divsel.
- Latency, with transfer edge T and S=SETTLE_CYCLES:
  - No change: done high in cycle T+1.
  - Single-field change: done high in cycle T+S+1.
  - Both fields change: done high in cycle T+2S+1.
  - Next acceptance is possible at the first edge after DONE.
- busy rises in the cycle after the transfer and falls in the cycle after DONE.
- Request inputs arriving while busy are ignored; no ready is issued. They are arbitrated on return to IDLE.
- cur_mode always equals {clksel, divsel} combinationally.

Test Plan:
- Reset, then req0 mode=10 at edge T, S=8: clksel=1 after edge T, divsel stays 0, busy=1 during T+1..T+9, done=1 with done_id=0 in cycle T+9, cur_mode=10.
- From 00, req1 mode=11: clksel rises after T; divsel rises exactly 8 cycles later; done in cycle T+17; outputs are never both changed at once.
- req0 and req1 both valid in IDLE after reset, modes 01 and 10: req0 granted first (done_id=0), then req1 on the next IDLE (done_id=1). With both held valid again, the grant order alternates.
- Request mode equal to cur_mode=01: ready in IDLE, done in cycle T+1, no output toggle, busy high for one cycle.
- rst_n low during SEL_WAIT after clksel=1: clksel=divsel=0 immediately, busy=0, no done pulse; after release, a new req0 is granted first.
- req1_valid pulsed for one cycle while busy, then dropped: no req1_ready, no done for req1, state returns to IDLE and stays idle.
